// File: rtl/victim_way_selector_pkg.sv
// victim_way_selector_pkg: shared constants and victim-response type.
// Revision 1.0
`default_nettype none
package victim_way_selector_pkg;

  localparam int NWAYS_MIN = 2;
  localparam int NWAYS_MAX = 16;
  localparam int WAYW_MAX  = 4;

  typedef struct packed {
    logic [WAYW_MAX-1:0] way;
    logic                invalid;
    logic                none;
  } victim_resp_t;

endpackage
`default_nettype wire

// File: rtl/victim_way_selector_pick.sv
// way_rotate_pick: first set bit of mask at or after start, wrapping modulo N.
// Revision 1.0
`default_nettype none
module way_rotate_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] way_o,
  output logic         found_o
);

  logic [W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest hit is the last assignment.
  always_comb begin
    way_o   = '0;
    found_o = 1'b0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = start_i + W'(k);
      if (mask_i[w_idx]) begin
        way_o   = w_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/victim_way_selector.sv
// victim_way_selector: picks a replacement way (empty first, else LFSR-seeded rotate).
// Revision 1.0
`default_nettype none
module victim_way_selector
  import victim_way_selector_pkg::*;
#(
  parameter int NWAYS = 8,
  parameter int WAYW  = $clog2(NWAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      io_lfsr_bits,
  output logic             io_lfsr_increment,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [NWAYS-1:0] io_req_valid_mask,
  input  logic [NWAYS-1:0] io_req_lock_mask,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [WAYW-1:0]  io_resp_way,
  output logic             io_resp_invalid,
  output logic             io_resp_none,
  output logic [15:0]      io_rand_count
);

  logic         resp_valid_q, resp_valid_d;
  victim_resp_t resp_q, resp_d;
  logic [WAYW-1:0] last_rand_q, last_rand_d;
  logic [15:0]  rand_count_q, rand_count_d;

  logic [NWAYS-1:0] w_cand, w_empty;
  logic [WAYW-1:0]  w_empty_way, w_rand_way, w_avoid_way, w_final_way;
  logic             w_empty_found, w_rand_found, w_avoid_found;
  logic             w_multi, w_accept, w_rand_path;
  logic             unused_bits;

  assign w_cand  = ~io_req_lock_mask;
  assign w_empty = w_cand & ~io_req_valid_mask;
  assign w_multi = (w_cand & (w_cand - 1'b1)) != '0;

  way_rotate_pick #(.N(NWAYS), .W(WAYW)) u_pick_empty (
    .mask_i (w_empty), .start_i ('0),
    .way_o  (w_empty_way), .found_o (w_empty_found)
  );

  way_rotate_pick #(.N(NWAYS), .W(WAYW)) u_pick_rand (
    .mask_i (w_cand), .start_i (io_lfsr_bits[WAYW-1:0]),
    .way_o  (w_rand_way), .found_o (w_rand_found)
  );

  // Searching from the slot after the random hit yields the next candidate.
  way_rotate_pick #(.N(NWAYS), .W(WAYW)) u_pick_avoid (
    .mask_i (w_cand), .start_i (w_rand_way + 1'b1),
    .way_o  (w_avoid_way), .found_o (w_avoid_found)
  );

  assign w_final_way = (w_rand_way == last_rand_q && w_multi && w_avoid_found)
                       ? w_avoid_way : w_rand_way;

  assign io_req_ready      = !resp_valid_q || io_resp_ready;
  assign w_accept          = io_req_valid && io_req_ready;
  assign w_rand_path       = !w_empty_found && w_rand_found;
  assign io_lfsr_increment = w_accept && w_rand_path && reset;

  always_comb begin
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    last_rand_d  = last_rand_q;
    rand_count_d = rand_count_q;
    if (io_resp_ready) resp_valid_d = 1'b0;
    if (w_accept) begin
      resp_valid_d = 1'b1;
      resp_d       = '0;
      if (w_empty_found) begin
        resp_d.way[WAYW-1:0] = w_empty_way;
        resp_d.invalid       = 1'b1;
      end else if (w_rand_found) begin
        resp_d.way[WAYW-1:0] = w_final_way;
        last_rand_d          = w_final_way;
        if (rand_count_q != 16'hFFFF) rand_count_d = rand_count_q + 16'd1;
      end else begin
        resp_d.none = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      last_rand_q  <= '0;
      rand_count_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      last_rand_q  <= last_rand_d;
      rand_count_q <= rand_count_d;
    end
  end

  assign io_resp_valid   = resp_valid_q;
  assign io_resp_way     = resp_q.way[WAYW-1:0];
  assign io_resp_invalid = resp_q.invalid;
  assign io_resp_none    = resp_q.none;
  assign io_rand_count   = rand_count_q;

  assign unused_bits = ^{io_lfsr_bits, resp_q.way};

endmodule
`default_nettype wire

// File: tb/tb_victim_way_selector.sv
// tb_victim_way_selector: directed vectors for victim_way_selector (NWAYS=8).
// Revision 1.0
`default_nettype none
module tb_victim_way_selector;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] io_lfsr_bits = '0;
  logic        io_lfsr_increment;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [7:0]  io_req_valid_mask = '0;
  logic [7:0]  io_req_lock_mask = '0;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b1;
  logic [2:0]  io_resp_way;
  logic        io_resp_invalid;
  logic        io_resp_none;
  logic [15:0] io_rand_count;

  int n_chk  = 0;
  int n_pass = 0;

  victim_way_selector #(.NWAYS(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_lfsr_bits      (io_lfsr_bits),
    .io_lfsr_increment (io_lfsr_increment),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_valid_mask (io_req_valid_mask),
    .io_req_lock_mask  (io_req_lock_mask),
    .io_resp_valid     (io_resp_valid),
    .io_resp_ready     (io_resp_ready),
    .io_resp_way       (io_resp_way),
    .io_resp_invalid   (io_resp_invalid),
    .io_resp_none      (io_resp_none),
    .io_rand_count     (io_rand_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [7:0] vm, input logic [7:0] lm,
                       input logic [15:0] lfsr, input logic rr);
    io_req_valid      = rv;
    io_req_valid_mask = vm;
    io_req_lock_mask  = lm;
    io_lfsr_bits      = lfsr;
    io_resp_ready     = rr;
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [2:0] way, input logic inv,
                            input logic none, input logic [15:0] cnt);
    chk({tag, "_valid"}, 32'(io_resp_valid), 32'd1);
    chk({tag, "_way"},   32'(io_resp_way), 32'(way));
    chk({tag, "_inv"},   32'(io_resp_invalid), 32'(inv));
    chk({tag, "_none"},  32'(io_resp_none), 32'(none));
    chk({tag, "_cnt"},   32'(io_rand_count), 32'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 8'hFF, 8'h00, 16'h0005, 1'b1);
    chk("rst_ready", 32'(io_req_ready), 32'd1);
    chk("rst_inc",   32'(io_lfsr_increment), 32'd0);
    tick();
    chk("rst_valid", 32'(io_resp_valid), 32'd0);
    chk("rst_way",   32'(io_resp_way), 32'd0);
    chk("rst_cnt",   32'(io_rand_count), 32'd0);
    chk("rst_inv",   32'(io_resp_invalid), 32'd0);
    chk("rst_none",  32'(io_resp_none), 32'd0);
    reset = 1'b1;
    #1;

    drive(1'b1, 8'hFF, 8'h00, 16'h0005, 1'b1);
    chk("r5_inc", 32'(io_lfsr_increment), 32'd1);
    tick();
    check_resp("r5", 3'd5, 1'b0, 1'b0, 16'd1);

    drive(1'b1, 8'hFF, 8'h20, 16'h0005, 1'b1);
    tick();
    check_resp("lock5", 3'd6, 1'b0, 1'b0, 16'd2);

    drive(1'b1, 8'hFF, 8'h20, 16'h0006, 1'b1);
    tick();
    check_resp("avoid6", 3'd7, 1'b0, 1'b0, 16'd3);

    drive(1'b1, 8'hB7, 8'h00, 16'h0001, 1'b1);
    chk("empty_inc", 32'(io_lfsr_increment), 32'd0);
    tick();
    check_resp("empty", 3'd3, 1'b1, 1'b0, 16'd3);

    drive(1'b1, 8'hFF, 8'hFF, 16'h0003, 1'b1);
    chk("none_inc", 32'(io_lfsr_increment), 32'd0);
    tick();
    check_resp("none", 3'd0, 1'b0, 1'b1, 16'd3);

    drive(1'b1, 8'hFF, 8'h7F, 16'h0007, 1'b1);
    tick();
    check_resp("single7", 3'd7, 1'b0, 1'b0, 16'd4);

    drive(1'b1, 8'hFF, 8'h00, 16'h0002, 1'b1);
    tick();
    check_resp("pre_hold", 3'd2, 1'b0, 1'b0, 16'd5);

    drive(1'b1, 8'h00, 8'h00, 16'hFFF4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", 32'(io_req_ready), 32'd0);
      chk("hold_inc",   32'(io_lfsr_increment), 32'd0);
      tick();
      check_resp("hold", 3'd2, 1'b0, 1'b0, 16'd5);
    end

    // Upper LFSR bits must be ignored: start index is 4.
    drive(1'b1, 8'hFF, 8'h00, 16'hFFF4, 1'b1);
    chk("b2b_ready", 32'(io_req_ready), 32'd1);
    chk("b2b_inc",   32'(io_lfsr_increment), 32'd1);
    tick();
    check_resp("b2b", 3'd4, 1'b0, 1'b0, 16'd6);

    drive(1'b0, 8'hFF, 8'h00, 16'h0000, 1'b1);
    tick();
    chk("drain_valid", 32'(io_resp_valid), 32'd0);

    drive(1'b1, 8'hFF, 8'h00, 16'h0000, 1'b1);
    tick();
    check_resp("pre_rst", 3'd0, 1'b0, 1'b0, 16'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(io_resp_valid), 32'd0);
    chk("async_cnt",   32'(io_rand_count), 32'd0);
    chk("async_way",   32'(io_resp_way), 32'd0);
    chk("async_ready", 32'(io_req_ready), 32'd1);
    chk("async_inc",   32'(io_lfsr_increment), 32'd0);
    tick();
    chk("drop_valid", 32'(io_resp_valid), 32'd0);
    reset = 1'b1;
    #1;

    // last_rand is 0 after reset: wrap lands on 0, avoidance moves to 1.
    drive(1'b1, 8'hFF, 8'hF0, 16'h0006, 1'b1);
    tick();
    check_resp("wrap_avoid", 3'd1, 1'b0, 1'b0, 16'd1);

    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
